// File: rtl/ctx_switch_sequencer.sv
// Context-switch register mover: streams r1..r(N-1) of the outgoing process to its DMEM
// save area, then reloads the incoming process's area into the register file.
module ctx_switch_sequencer #(
    parameter int NUM_PROCS  = 10,
    parameter int NUM_REGS   = 32,
    parameter int CTX_BASE   = 1300,
    parameter int CTX_STRIDE = 32,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic              save_en_i,
    input  logic              load_en_i,
    input  logic [3:0]        save_proc_i,
    input  logic [3:0]        load_proc_i,
    output logic [4:0]        rf_raddr_o,
    input  logic [31:0]       rf_rdata_i,
    output logic              rf_we_o,
    output logic [4:0]        rf_waddr_o,
    output logic [31:0]       rf_wdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    typedef enum logic [2:0] {S_IDLE, S_SAVE, S_LOAD, S_LTAIL, S_DONE} state_t;

    localparam logic [4:0] LAST = 5'(NUM_REGS - 1);

    function automatic logic [ADDR_W-1:0] base_of(input logic [3:0] p);
        return ADDR_W'(CTX_BASE) + (ADDR_W'(p) - ADDR_W'(1)) * ADDR_W'(CTX_STRIDE);
    endfunction

    function automatic logic id_ok(input logic [3:0] p);
        return (p != 4'd0) && (32'(p) <= 32'(NUM_PROCS));
    endfunction

    state_t              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic                load_en_q, load_en_d;
    logic [ADDR_W-1:0]   sbase_q, sbase_d, lbase_q, lbase_d;
    logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                rf_we_q, rf_we_d, mem_we_q, mem_we_d;
    logic [4:0]          rf_raddr_q, rf_raddr_d, rf_waddr_q, rf_waddr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load_en_d = load_en_q;
        sbase_d   = sbase_q;
        lbase_d   = lbase_q;
        error_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if ((save_en_i && !id_ok(save_proc_i)) || (load_en_i && !id_ok(load_proc_i))) begin
                        error_d = 1'b1;
                    end else begin
                        idx_d     = 5'd1;
                        load_en_d = load_en_i;
                        sbase_d   = base_of(save_proc_i);
                        lbase_d   = base_of(load_proc_i);
                        state_d   = save_en_i ? S_SAVE : (load_en_i ? S_LOAD : S_DONE);
                    end
                end
            end
            S_SAVE: begin
                if (idx_q == LAST) begin
                    idx_d   = 5'd1;
                    state_d = load_en_q ? S_LOAD : S_DONE;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_LOAD: begin
                if (idx_q == LAST) state_d = S_LTAIL;
                else               idx_d   = idx_q + 5'd1;
            end
            S_LTAIL: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they land registered in that state's cycle.
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rf_we_d    = 1'b0;
        mem_we_d   = 1'b0;
        rf_raddr_d = 5'd0;
        rf_waddr_d = 5'd0;
        mem_addr_d = '0;
        case (state_d)
            S_SAVE: begin
                busy_d     = 1'b1;
                rf_raddr_d = idx_d;
                mem_addr_d = sbase_d + ADDR_W'(idx_d);
                mem_we_d   = 1'b1;
            end
            S_LOAD: begin
                busy_d     = 1'b1;
                mem_addr_d = lbase_d + ADDR_W'(idx_d);
                // Sync DMEM: data for idx-1 arrives now; the first LOAD cycle has nothing yet.
                rf_we_d    = (idx_d != 5'd1);
                rf_waddr_d = idx_d - 5'd1;
            end
            S_LTAIL: begin
                busy_d     = 1'b1;
                rf_we_d    = 1'b1;
                rf_waddr_d = LAST;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            idx_q      <= 5'd1;
            load_en_q  <= 1'b0;
            sbase_q    <= '0;
            lbase_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            rf_raddr_q <= 5'd0;
            rf_waddr_q <= 5'd0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            load_en_q  <= load_en_d;
            sbase_q    <= sbase_d;
            lbase_q    <= lbase_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            rf_we_q    <= rf_we_d;
            mem_we_q   <= mem_we_d;
            rf_raddr_q <= rf_raddr_d;
            rf_waddr_q <= rf_waddr_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign rf_raddr_o  = rf_raddr_q;
    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_we_q ? mem_rdata_i : 32'd0;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_we_q ? rf_rdata_i : 32'd0;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_ctx_switch_sequencer.sv
// Bench for ctx_switch_sequencer: RF/DMEM environment models, table + random vectors
// checked against a whole-transfer reference model, plus restart and mid-sequence reset cases.
module tb_ctx_switch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, save_en, load_en;
    logic [3:0]  save_proc, load_proc;
    logic [4:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata, rf_wdata, mem_wdata, mem_rdata;
    logic        rf_we, mem_we, busy, done, error;
    logic [31:0] mem_addr;

    logic [31:0] rf_mem [32];
    logic [31:0] dmem   [2048];
    logic [31:0] rf_exp [32];
    logic [31:0] dm_exp [2048];

    int nvec = 0, nbad = 0;
    int mw_cnt, rw_cnt, ovl_cnt, r0_cnt, err_cnt;
    bit busy_seen;

    typedef struct {
        bit         se, le;
        logic [3:0] sp, lp;
        bit         err;
        int         lat, mw, rw;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    ctx_switch_sequencer dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start),
        .save_en_i(save_en), .load_en_i(load_en),
        .save_proc_i(save_proc), .load_proc_i(load_proc),
        .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .done_o(done), .error_o(error)
    );

    // Register file (async read) and synchronous DMEM around the DUT.
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge clk) begin
        mem_rdata = dmem[mem_addr[10:0]];
        if (mem_we) dmem[mem_addr[10:0]] = mem_wdata;
        if (rf_we)  rf_mem[rf_waddr] = rf_wdata;
    end

    always @(negedge clk) begin
        if (mem_we) mw_cnt++;
        if (rf_we)  rw_cnt++;
        if (mem_we && rf_we) ovl_cnt++;
        if (rf_we && rf_waddr == 5'd0) r0_cnt++;
        if (error) err_cnt++;
        if (busy)  busy_seen = 1'b1;
    end

    task automatic chk(input string nm, input longint got, input longint exp);
        nvec++;
        if (got != exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int base(input int p);
        return 1300 + (p - 1) * 32;
    endfunction

    function automatic bit valid(input int p);
        return p >= 1 && p <= 10;
    endfunction

    function automatic vec_t model(input bit se, input bit le, input int sp, input int lp);
        vec_t v;
        v.se  = se;  v.le = le;
        v.sp  = 4'(sp); v.lp = 4'(lp);
        v.err = (se && !valid(sp)) || (le && !valid(lp));
        v.lat = v.err ? -1 : 31 * int'(se) + 32 * int'(le) + 1;
        v.mw  = (!v.err && se) ? 31 : 0;
        v.rw  = (!v.err && le) ? 31 : 0;
        return v;
    endfunction

    task automatic randomize_mems();
        for (int k = 0; k < 32; k++)   rf_mem[k] = $urandom;
        for (int a = 0; a < 2048; a++) dmem[a]   = $urandom;
    endtask

    task automatic run_and_check(input vec_t v, input int restart_at);
        int lat;
        bit errp;
        int bad_rf, bad_dm;
        for (int k = 0; k < 32; k++)   rf_exp[k] = rf_mem[k];
        for (int a = 0; a < 2048; a++) dm_exp[a] = dmem[a];
        if (!v.err) begin
            if (v.se) for (int k = 1; k < 32; k++) dm_exp[base(int'(v.sp)) + k] = rf_exp[k];
            if (v.le) for (int k = 1; k < 32; k++) rf_exp[k] = dm_exp[base(int'(v.lp)) + k];
        end
        @(negedge clk);
        save_en = v.se; load_en = v.le; save_proc = v.sp; load_proc = v.lp; start = 1'b1;
        mw_cnt = 0; rw_cnt = 0; ovl_cnt = 0; r0_cnt = 0; err_cnt = 0; busy_seen = 1'b0;
        lat = -1; errp = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == restart_at) begin
                start = 1'b1; save_en = 1'b1; load_en = 1'b1; save_proc = 4'd5; load_proc = 4'd9;
            end
            if (error) errp = 1'b1;
            if (done) begin lat = n; break; end
            if (errp && n >= 3) break;
        end
        start = 1'b0;
        bad_rf = 0; bad_dm = 0;
        for (int k = 0; k < 32; k++)   if (rf_mem[k] !== rf_exp[k]) bad_rf++;
        for (int a = 0; a < 2048; a++) if (dmem[a] !== dm_exp[a])   bad_dm++;
        chk("latency", lat, v.lat);
        chk("error_flag", errp, v.err);
        chk("error_pulses", err_cnt, v.err ? 1 : 0);
        chk("busy_seen", busy_seen, (v.se || v.le) && !v.err);
        chk("mem_writes", mw_cnt, v.mw);
        chk("rf_writes", rw_cnt, v.rw);
        chk("strobe_overlap", ovl_cnt, 0);
        chk("r0_writes", r0_cnt, 0);
        chk("rf_contents", bad_rf, 0);
        chk("dmem_contents", bad_dm, 0);
    endtask

    initial begin
        bit any;
        reset_n = 1'b0; start = 1'b0; save_en = 1'b0; load_en = 1'b0;
        save_proc = 4'd0; load_proc = 4'd0;
        randomize_mems();
        repeat (2) @(negedge clk);
        any = |{busy, done, error, rf_we, mem_we, rf_raddr, rf_waddr, rf_wdata, mem_addr, mem_wdata};
        chk("reset_outputs", any, 0);
        reset_n = 1'b1;

        // Save 3 -> load 7 with the documented preload.
        for (int a = 0; a < 2048; a++) dmem[a] = 32'hDEAD_0000 + 32'(a);
        for (int k = 0; k < 32; k++) rf_mem[k] = 32'h300 + 32'(k);
        rf_mem[0] = 32'h0;
        for (int k = 1; k < 32; k++) dmem[1492 + k] = 32'h700 + 32'(k);
        run_and_check(model(1, 1, 3, 7), 0);
        chk("dmem_1365", dmem[1365], 32'h301);
        chk("dmem_1395", dmem[1395], 32'h31F);
        chk("rf_r1", rf_mem[1], 32'h701);
        chk("rf_r31", rf_mem[31], 32'h71F);
        chk("rf_r0", rf_mem[0], 32'h0);

        tbl[0] = '{1'b1, 1'b1, 4'd3,  4'd7,  1'b0, 64, 31, 31};
        tbl[1] = '{1'b1, 1'b0, 4'd10, 4'd0,  1'b0, 32, 31, 0};
        tbl[2] = '{1'b0, 1'b1, 4'd0,  4'd5,  1'b0, 33, 0,  31};
        tbl[3] = '{1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1,  0,  0};
        tbl[4] = '{1'b1, 1'b1, 4'd4,  4'd4,  1'b0, 64, 31, 31};
        tbl[5] = '{1'b1, 1'b0, 4'd0,  4'd3,  1'b1, -1, 0,  0};
        tbl[6] = '{1'b1, 1'b1, 4'd2,  4'd11, 1'b1, -1, 0,  0};
        tbl[7] = '{1'b0, 1'b1, 4'd3,  4'd15, 1'b1, -1, 0,  0};
        tbl[8] = '{1'b1, 1'b0, 4'd11, 4'd1,  1'b1, -1, 0,  0};
        tbl[9] = '{1'b1, 1'b1, 4'd1,  4'd10, 1'b0, 64, 31, 31};
        for (int i = 0; i < 10; i++) begin
            randomize_mems();
            run_and_check(tbl[i], 0);
        end

        for (int i = 0; i < 20; i++) begin
            randomize_mems();
            run_and_check(model($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                $urandom_range(0, 12), $urandom_range(0, 12)), 0);
        end

        // A second start at cycle 10 must be ignored.
        randomize_mems();
        run_and_check(model(1, 1, 3, 7), 10);

        // Async reset at cycle 20 of SAVE; writes for idx 1..19 have landed, idx 20 has not.
        for (int a = 0; a < 2048; a++) dmem[a] = 32'hDEAD_0000 + 32'(a);
        for (int k = 0; k < 32; k++) rf_mem[k] = 32'h300 + 32'(k);
        @(negedge clk);
        save_en = 1'b1; load_en = 1'b1; save_proc = 4'd3; load_proc = 4'd7; start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_reset_mem_we", mem_we, 1);
        #2 reset_n = 1'b0;
        #1;
        any = |{busy, done, error, rf_we, mem_we, rf_raddr, rf_waddr, rf_wdata, mem_addr, mem_wdata};
        chk("async_reset_outputs", any, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", {busy, mem_we, rf_we, done}, 0);
        chk("partial_write_19", dmem[1364 + 19], 32'h313);
        chk("no_write_20", dmem[1364 + 20], 32'hDEAD_0000 + 32'(1364 + 20));
        randomize_mems();
        run_and_check(model(1, 1, 6, 2), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
